// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and compare result codes for alu_seq
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_NAND = 4'h6,
        OP_NOR  = 4'h7,
        OP_XOR  = 4'h8,
        OP_XNOR = 4'h9,
        OP_EQ   = 4'hA,
        OP_GT   = 4'hB,
        OP_LT   = 4'hC,
        OP_SHR  = 4'hD,
        OP_SHL  = 4'hE,
        OP_ROL  = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    localparam logic [1:0] CMP_EQ_CODE = 2'd1;
    localparam logic [1:0] CMP_GT_CODE = 2'd2;
    localparam logic [1:0] CMP_LT_CODE = 2'd3;

    // Opcode class as {shift, cmp, logic, arith}
    function automatic logic [3:0] op_class(input alu_op_e op);
        logic [3:0] cls;
        cls = 4'b0000;
        if (op <= OP_DIV)       cls[0] = 1'b1;
        else if (op <= OP_XNOR) cls[1] = 1'b1;
        else if (op <= OP_LT)   cls[2] = 1'b1;
        else                    cls[3] = 1'b1;
        return cls;
    endfunction

endpackage

// File: rtl/alu_seq_div.sv
// rtl/alu_seq_div.sv - restoring divider, one quotient bit per cycle
module alu_seq_div import alu_pkg::*; #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_quo;
    logic [W-1:0]  r_dvs;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;

    logic [W-1:0]  w_rem_src;
    logic [W-1:0]  w_quo_src;
    logic [W-1:0]  w_dvs_src;
    logic [W:0]    w_shift;
    logic [W:0]    w_trial;
    logic          w_bit;
    logic [W-1:0]  w_rem_next;
    logic [W-1:0]  w_quo_next;

    // The first step runs on the start edge straight from the operands,
    // so the last bit settles W-1 edges later.
    always_comb begin
        w_rem_src  = start ? '0 : r_rem;
        w_quo_src  = start ? dividend : r_quo;
        w_dvs_src  = start ? divisor : r_dvs;
        w_shift    = {w_rem_src, w_quo_src[W-1]};
        w_trial    = w_shift - {1'b0, w_dvs_src};
        w_bit      = ~w_trial[W];
        w_rem_next = w_bit ? w_trial[W-1:0] : w_shift[W-1:0];
        w_quo_next = {w_quo_src[W-2:0], w_bit};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_rem  <= w_rem_next;
                r_quo  <= w_quo_next;
                r_dvs  <= divisor;
                r_cnt  <= CW'(W - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU top, iterative divide; optional flags via ALU_FLAGS_EN
module alu_seq import alu_pkg::*; #(
    parameter int OPER_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic [OPER_WIDTH-1:0]   A,
    input  logic [OPER_WIDTH-1:0]   B,
    input  logic [3:0]              ALU_FUN,
    output logic                    IN_READY,
    output logic [2*OPER_WIDTH-1:0] ALU_OUT,
    output logic                    OUT_VALID,
    output logic                    DIV_BY_ZERO
`ifdef ALU_FLAGS_EN
    ,
    output logic                    ARITH_FLAG,
    output logic                    LOGIC_FLAG,
    output logic                    CMP_FLAG,
    output logic                    SHIFT_FLAG,
    output logic                    ZERO_FLAG
`endif
);

    localparam int OUT_WIDTH = 2 * OPER_WIDTH;
    localparam logic [OUT_WIDTH-3:0] CMP_PAD = '0;

    alu_state_e             r_state;
    logic [OUT_WIDTH-1:0]   r_alu_out;
    logic                   r_out_valid;
    logic                   r_div_by_zero;
    logic                   r_in_ready;

    alu_op_e                w_op;
    logic [OUT_WIDTH-1:0]   w_a_ext;
    logic [OUT_WIDTH-1:0]   w_b_ext;
    logic [OPER_WIDTH-1:0]  w_logic;
    logic [OUT_WIDTH-1:0]   w_result;
    logic                   w_accept;
    logic                   w_div_start;
    logic                   w_div_busy;
    logic                   w_div_done;
    logic [OPER_WIDTH-1:0]  w_quo;
    logic [OPER_WIDTH-1:0]  w_rem;
    logic                   w_load;
    logic [OUT_WIDTH-1:0]   w_load_val;

    assign w_op        = alu_op_e'(ALU_FUN);
    assign w_a_ext     = {{OPER_WIDTH{1'b0}}, A};
    assign w_b_ext     = {{OPER_WIDTH{1'b0}}, B};
    assign w_accept    = EN & r_in_ready & ~w_div_busy;
    assign w_div_start = w_accept & (w_op == OP_DIV) & (B != '0);

    always_comb begin
        w_logic = '0;
        case (w_op)
            OP_AND:  w_logic = A & B;
            OP_OR:   w_logic = A | B;
            OP_NAND: w_logic = ~(A & B);
            OP_NOR:  w_logic = ~(A | B);
            OP_XOR:  w_logic = A ^ B;
            OP_XNOR: w_logic = ~(A ^ B);
            default: w_logic = '0;
        endcase
    end

    always_comb begin
        w_result = '0;
        case (w_op)
            OP_ADD:  w_result = w_a_ext + w_b_ext;
            OP_SUB:  w_result = w_a_ext - w_b_ext;
            OP_MUL:  w_result = w_a_ext * w_b_ext;
            OP_DIV:  w_result = {A, {OPER_WIDTH{1'b1}}};
            OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR:
                     w_result = {{OPER_WIDTH{1'b0}}, w_logic};
            OP_EQ:   w_result = (A == B) ? {CMP_PAD, CMP_EQ_CODE} : '0;
            OP_GT:   w_result = (A > B)  ? {CMP_PAD, CMP_GT_CODE} : '0;
            OP_LT:   w_result = (A < B)  ? {CMP_PAD, CMP_LT_CODE} : '0;
            OP_SHR:  w_result = w_a_ext >> 1;
            OP_SHL:  w_result = w_a_ext << 1;
            OP_ROL:  w_result = {{OPER_WIDTH{1'b0}}, A[OPER_WIDTH-2:0], A[OPER_WIDTH-1]};
            default: w_result = '0;
        endcase
    end

    alu_seq_div #(.W(OPER_WIDTH)) u_div (
        .CLK       (CLK),
        .RST       (RST),
        .start     (w_div_start),
        .dividend  (A),
        .divisor   (B),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    // A divide-by-zero request never enters DIV and loads like a single-cycle op.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = w_result;
        if (r_state == DIV) begin
            w_load     = w_div_done;
            w_load_val = {w_rem, w_quo};
        end else if (w_accept && !w_div_start) begin
            w_load = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state       <= IDLE;
            r_alu_out     <= '0;
            r_out_valid   <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_in_ready    <= 1'b1;
        end else begin
            r_out_valid   <= 1'b0;
            r_div_by_zero <= 1'b0;
            if (w_load) begin
                r_alu_out     <= w_load_val;
                r_out_valid   <= 1'b1;
                r_div_by_zero <= (r_state != DIV) && (w_op == OP_DIV);
            end
            case (r_state)
                DIV: begin
                    if (w_div_done) begin
                        r_state    <= DONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    if (w_div_start) begin
                        r_state    <= DIV;
                        r_in_ready <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign IN_READY    = r_in_ready;
    assign ALU_OUT     = r_alu_out;
    assign OUT_VALID   = r_out_valid;
    assign DIV_BY_ZERO = r_div_by_zero;

`ifdef ALU_FLAGS_EN
    alu_op_e    w_load_op;
    logic [4:0] r_flags;

    assign w_load_op = (r_state == DIV) ? OP_DIV : w_op;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_flags <= '0;
        end else if (w_load) begin
            r_flags <= {(w_load_val == '0), op_class(w_load_op)};
        end else begin
            r_flags <= '0;
        end
    end

    assign ARITH_FLAG = r_flags[0];
    assign LOGIC_FLAG = r_flags[1];
    assign CMP_FLAG   = r_flags[2];
    assign SHIFT_FLAG = r_flags[3];
    assign ZERO_FLAG  = r_flags[4];
`else
    // Default build carries no flag state.
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq (build with and without ALU_FLAGS_EN)
module tb_alu_seq;

    localparam int W = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          EN = 1'b0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [3:0]    ALU_FUN = '0;
    logic          IN_READY;
    logic [2*W-1:0] ALU_OUT;
    logic          OUT_VALID;
    logic          DIV_BY_ZERO;
`ifdef ALU_FLAGS_EN
    logic ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG, ZERO_FLAG;
`endif

    alu_seq #(.OPER_WIDTH(W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .EN          (EN),
        .A           (A),
        .B           (B),
        .ALU_FUN     (ALU_FUN),
        .IN_READY    (IN_READY),
        .ALU_OUT     (ALU_OUT),
        .OUT_VALID   (OUT_VALID),
        .DIV_BY_ZERO (DIV_BY_ZERO)
`ifdef ALU_FLAGS_EN
        ,
        .ARITH_FLAG  (ARITH_FLAG),
        .LOGIC_FLAG  (LOGIC_FLAG),
        .CMP_FLAG    (CMP_FLAG),
        .SHIFT_FLAG  (SHIFT_FLAG),
        .ZERO_FLAG   (ZERO_FLAG)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] out;
        logic        dbz;
        logic [4:0]  flags;   // {zero, shift, cmp, logic, arith}
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b, input int op);
        exp_t e;
        int   r;
        e.dbz = 1'b0;
        case (op)
            0:  r = a + b;
            1:  r = a - b;
            2:  r = a * b;
            3:  begin
                    if (b == 0) begin
                        r = (a << 8) | 'hFF;
                        e.dbz = 1'b1;
                    end else begin
                        r = ((a % b) << 8) | (a / b);
                    end
                end
            4:  r = a & b;
            5:  r = a | b;
            6:  r = (~(a & b)) & 'hFF;
            7:  r = (~(a | b)) & 'hFF;
            8:  r = a ^ b;
            9:  r = (~(a ^ b)) & 'hFF;
            10: r = (a == b) ? 1 : 0;
            11: r = (a > b) ? 2 : 0;
            12: r = (a < b) ? 3 : 0;
            13: r = a >> 1;
            14: r = a << 1;
            default: r = ((a << 1) | (a >> 7)) & 'hFF;
        endcase
        e.out   = 16'(r & 'hFFFF);
        e.flags = {(e.out == 16'h0), (op >= 13), (op >= 10 && op <= 12),
                   (op >= 4 && op <= 9), (op <= 3)};
        return e;
    endfunction

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (RST && OUT_VALID) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 64'(OUT_VALID), 64'd0);
            end else begin
                e = sb.pop_front();
                check("alu_out", 64'(ALU_OUT), 64'(e.out));
                check("div_by_zero", 64'(DIV_BY_ZERO), 64'(e.dbz));
`ifdef ALU_FLAGS_EN
                check("flags", 64'({ZERO_FLAG, SHIFT_FLAG, CMP_FLAG, LOGIC_FLAG, ARITH_FLAG}),
                      64'(e.flags));
`endif
            end
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input bit push);
        @(negedge CLK);
        EN = 1'b1;
        A = a;
        B = b;
        ALU_FUN = op;
        if (push) sb.push_back(model(int'(a), int'(b), int'(op)));
        @(posedge CLK);
        #1 EN = 1'b0;
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [3:0] rop;

        repeat (3) @(negedge CLK);
        check("rst_alu_out", 64'(ALU_OUT), 64'd0);
        check("rst_valid", 64'(OUT_VALID), 64'd0);
        check("rst_dbz", 64'(DIV_BY_ZERO), 64'd0);
        check("rst_ready", 64'(IN_READY), 64'd1);
        RST = 1'b1;

        issue(8'd200, 8'd100, 4'h0, 1'b1);
        @(negedge CLK);
        check("add_valid", 64'(OUT_VALID), 64'd1);
        @(negedge CLK);
        check("add_valid_drop", 64'(OUT_VALID), 64'd0);
        check("add_hold", 64'(ALU_OUT), 64'h012C);

        issue(8'd5, 8'd7, 4'h1, 1'b1);
        issue(8'hFF, 8'hFF, 4'h2, 1'b1);
        @(negedge CLK);
        check("b2b_valid", 64'(OUT_VALID), 64'd1);

        issue(8'd100, 8'd7, 4'h3, 1'b1);
        for (int i = 0; i < W; i++) begin
            @(negedge CLK);
            check("div_busy", 64'(IN_READY), 64'd0);
            check("div_no_valid", 64'(OUT_VALID), 64'd0);
            @(posedge CLK);
        end
        @(negedge CLK);
        check("div_ready_done", 64'(IN_READY), 64'd1);
        check("div_valid", 64'(OUT_VALID), 64'd1);

        issue(8'h55, 8'h00, 4'h3, 1'b1);
        @(negedge CLK);
        check("dbz_ready", 64'(IN_READY), 64'd1);
        check("dbz_valid", 64'(OUT_VALID), 64'd1);

        issue(8'd9, 8'd3, 4'hB, 1'b1);
        issue(8'd3, 8'd9, 4'hB, 1'b1);
        issue(8'd4, 8'd4, 4'hA, 1'b1);
        issue(8'd1, 8'd2, 4'hC, 1'b1);
        issue(8'hFF, 8'hFF, 4'h0, 1'b1);
        issue(8'd0, 8'hFF, 4'h1, 1'b1);
        issue(8'h80, 8'd0, 4'hE, 1'b1);
        issue(8'h80, 8'd0, 4'hF, 1'b1);
        issue(8'h81, 8'd0, 4'hD, 1'b1);
        issue(8'h0F, 8'hF0, 4'h4, 1'b1);
        issue(8'hFF, 8'd1, 4'h3, 1'b1);
        repeat (W + 2) @(negedge CLK);
        issue(8'd0, 8'd5, 4'h3, 1'b1);
        repeat (W + 2) @(negedge CLK);

        for (int i = 0; i < 40; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rop = 4'($urandom_range(0, 15));
            if (rop == 4'h3) rb = 8'd0;
            issue(ra, rb, rop, 1'b1);
        end
        repeat (2) @(negedge CLK);

        issue(8'd200, 8'd9, 4'h3, 1'b1);
        repeat (2) @(posedge CLK);
        issue(8'd1, 8'd1, 4'h0, 1'b0);
        repeat (W + 4) @(negedge CLK);
        check("guard_drain", 64'(sb.size()), 64'd0);

        issue(8'd250, 8'd3, 4'h3, 1'b0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("abort_alu_out", 64'(ALU_OUT), 64'd0);
        check("abort_valid", 64'(OUT_VALID), 64'd0);
        check("abort_dbz", 64'(DIV_BY_ZERO), 64'd0);
        check("abort_ready", 64'(IN_READY), 64'd1);
`ifdef ALU_FLAGS_EN
        check("abort_flags", 64'({ZERO_FLAG, SHIFT_FLAG, CMP_FLAG, LOGIC_FLAG, ARITH_FLAG}), 64'd0);
`endif
        @(negedge CLK);
        RST = 1'b1;
        repeat (W + 4) @(negedge CLK);
        check("abort_ready_after", 64'(IN_READY), 64'd1);

        issue(8'd7, 8'd6, 4'h2, 1'b1);
        repeat (2) @(negedge CLK);
        check("final_drain", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
